pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high; sampled on rising edge of clk only.
REQ-003 SHALL: load_use_hazard  in  1  ID-stage load-use stall request (ID StallCheck).
REQ-004 SHALL: branch_taken  in  1  ID-stage branch resolved taken (ID br).
REQ-005 SHALL: mem_req  in  1  MEM stage has a data-memory access in flight.
REQ-006 SHALL: mem_ready  in  1  data memory completes the access this cycle.
REQ-007 SHALL: pc_we  out  1  PC register write enable.
REQ-008 SHALL: if_id_we  out  1  IF/ID pipeline register write enable.
REQ-009 SHALL: if_id_flush  out  1  IF/ID register loads NOP.
REQ-010 SHALL: id_ex_flush  out  1  ID/EX register loads bubble (rd_we=0, alu_op=0).
REQ-011 SHALL: ex_mem_we  out  1  EX/MEM and MEM/WB register write enable.
REQ-012 SHALL: ctrl_state  out  2  current FSM state encoding.
REQ-013 SHALL: stall_cycles  out  32  performance counter, stalled cycles.
REQ-014 SHALL: flush_count  out  32  performance counter, branch flushes.

Function
REQ-015 SHALL: FSM states RUN=2'd0, LU_STALL=2'd1, BR_FLUSH=2'd2, MEM_WAIT=2'd3; ctrl_state is the registered state.
REQ-016 SHALL: control outputs are combinational from the current state and inputs, with zero-cycle latency.
REQ-017 SHALL: default outputs: pc_we=1, if_id_we=1, ex_mem_we=1, if_id_flush=0, id_ex_flush=0.
REQ-018 SHALL: priority in RUN is memory stall, then load-use, then branch; at most one condition acts per cycle.
REQ-019 SHALL: in RUN, when mem_req=1 and mem_ready=0, set pc_we=if_id_we=ex_mem_we=0 and no flush; next state is MEM_WAIT.
REQ-020 SHALL: in RUN, otherwise when load_use_hazard=1, set pc_we=0, if_id_we=0, id_ex_flush=1; next state is LU_STALL.
REQ-021 SHALL: in RUN, otherwise when branch_taken=1, set pc_we=1 and if_id_flush=1; next state is BR_FLUSH.
REQ-022 SHALL: in RUN with none of these conditions, use default outputs and remain in RUN.
REQ-023 SHALL: LU_STALL lasts exactly one cycle; load_use_hazard is ignored; a memory stall still applies per REQ-019 (next MEM_WAIT); branch_taken applies per REQ-021; otherwise next state is RUN.
REQ-024 SHALL: BR_FLUSH lasts exactly one cycle; branch_taken and load_use_hazard are ignored; a memory stall still applies per REQ-019; otherwise next state is RUN.
REQ-025 SHALL: in MEM_WAIT with mem_ready=0, freeze all stages (REQ-019 outputs) and remain, with no cycle limit.
REQ-026 SHALL: in MEM_WAIT with mem_ready=1, compute outputs and next state exactly as RUN with the memory-stall term forced false.
REQ-027 SHALL: mem_ready=1 while mem_req=0 has no effect.

Reset
REQ-028 SHALL: while reset=1, outputs are pc_we=0, if_id_we=0, ex_mem_we=0, if_id_flush=1, id_ex_flush=1.
REQ-029 SHALL: on a clock edge with reset=1, state becomes RUN and both counters become 0, overriding any in-progress stall or flush.
REQ-030 SHALL: after reset deasserts, the first cycle is evaluated as RUN.

Configuration
REQ-031 SHALL: macro HAZARD_PERF_CNT_EN gates the performance counters.
REQ-032 SHALL: when HAZARD_PERF_CNT_EN is defined, stall_cycles increments on each non-reset cycle with pc_we=0, and flush_count increments on each cycle with if_id_flush=1 and reset=0; both saturate at 32'hFFFF_FFFF.
REQ-033 SHALL: when HAZARD_PERF_CNT_EN is undefined, both ports are present and tied to 0, with no counter registers.

Verification
REQ-034 SHALL: load_use_hazard=1 for 2 cycles in RUN -> cycle0: pc_we=0, id_ex_flush=1, state->LU_STALL; cycle1: defaults, state->RUN; stall_cycles=1.
REQ-035 SHALL: branch_taken=1 for 2 cycles -> cycle0: if_id_flush=1; cycle1: no flush (BR_FLUSH), state->RUN; flush_count=1.
REQ-036 SHALL: mem_req=1 with mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles in MEM_WAIT, release on the 4th cycle, state->RUN; stall_cycles=3.
REQ-037 SHALL: mem stall + load_use_hazard + branch_taken all 1 in RUN -> freeze only; on release with load_use_hazard=1 -> id_ex_flush=1, state->LU_STALL.
REQ-038 SHALL: reset=1 asserted while in MEM_WAIT -> next state RUN, counters 0, flushes=1 during reset.
REQ-039 SHALL: build without HAZARD_PERF_CNT_EN, repeat REQ-034 -> stall_cycles=0 and flush_count=0 throughout.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller FSM, optional perf counters under HAZARD_PERF_CNT_EN
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_we,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, BR_FLUSH = 2'd2, MEM_WAIT = 2'd3} state_t;
  state_t state, next_state;
  logic stall, lu_act, br_act;
  assign ctrl_state = state;
  // hazard arbitration: memory freeze wins, then load-use, then branch; each state masks what it ignores
  always_comb begin
    stall       = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    lu_act      = !stall && load_use_hazard && (state == RUN || state == MEM_WAIT);
    br_act      = !stall && !lu_act && branch_taken && (state != BR_FLUSH);
    pc_we       = !reset && !stall && !lu_act;
    if_id_we    = !reset && !stall && !lu_act;
    ex_mem_we   = !reset && !stall;
    if_id_flush = reset || br_act;
    id_ex_flush = reset || lu_act;
    next_state  = stall ? MEM_WAIT : lu_act ? LU_STALL : br_act ? BR_FLUSH : RUN;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end
`ifdef HAZARD_PERF_CNT_EN
  // saturating stall and branch-flush counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 0, reset, load_use_hazard, branch_taken, mem_req, mem_ready;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we;
  logic [1:0] ctrl_state;
  logic [31:0] stall_cycles, flush_count;
  int total = 0, bad = 0;
  logic [31:0] exp_sc = 0, exp_fc = 0;
  logic [6:0] sb[$];
  logic [11:0] vec[30];
  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  localparam logic [4:0] DEF = 5'b11100, FRZ = 5'b00000, LU = 5'b00101, BR = 5'b11110, RST = 5'b00011;
  initial begin
    // {reset, lu, br, mem_req, mem_ready, {pc_we,if_id_we,ex_mem_we,if_id_flush,id_ex_flush}, next state}
    vec[0]  = {5'b10000, RST, 2'd0};
    vec[1]  = {5'b10000, RST, 2'd0};
    vec[2]  = {5'b00000, DEF, 2'd0};
    vec[3]  = {5'b01000, LU,  2'd1};
    vec[4]  = {5'b01000, DEF, 2'd0};
    vec[5]  = {5'b00100, BR,  2'd2};
    vec[6]  = {5'b00100, DEF, 2'd0};
    vec[7]  = {5'b00010, FRZ, 2'd3};
    vec[8]  = {5'b00010, FRZ, 2'd3};
    vec[9]  = {5'b00010, FRZ, 2'd3};
    vec[10] = {5'b00011, DEF, 2'd0};
    vec[11] = {5'b01110, FRZ, 2'd3};
    vec[12] = {5'b01111, LU,  2'd1};
    vec[13] = {5'b01100, BR,  2'd2};
    vec[14] = {5'b01100, DEF, 2'd0};
    vec[15] = {5'b01000, LU,  2'd1};
    vec[16] = {5'b00010, FRZ, 2'd3};
    vec[17] = {5'b00101, BR,  2'd2};
    vec[18] = {5'b00010, FRZ, 2'd3};
    vec[19] = {5'b00011, DEF, 2'd0};
    vec[20] = {5'b00001, DEF, 2'd0};
    vec[21] = {5'b00010, FRZ, 2'd3};
    vec[22] = {5'b00000, FRZ, 2'd3};
    vec[23] = {5'b00001, DEF, 2'd0};
    vec[24] = {5'b00010, FRZ, 2'd3};
    vec[25] = {5'b10010, RST, 2'd0};
    vec[26] = {5'b01000, LU,  2'd1};
    vec[27] = {5'b00000, DEF, 2'd0};
    vec[28] = {5'b00100, BR,  2'd2};
    vec[29] = {5'b00000, DEF, 2'd0};
    {reset, load_use_hazard, branch_taken, mem_req, mem_ready} = 5'b10000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 30; i++) begin
      logic [6:0] e;
      logic r;
      {reset, load_use_hazard, branch_taken, mem_req, mem_ready} = vec[i][11:7];
      r = vec[i][11];
      sb.push_back(vec[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("out%0d", i), {27'd0, pc_we, if_id_we, ex_mem_we, if_id_flush, id_ex_flush}, {27'd0, e[6:2]});
      @(posedge clk);
      #1;
      check($sformatf("state%0d", i), {30'd0, ctrl_state}, {30'd0, e[1:0]});
      if (r) begin
        exp_sc = 0;
        exp_fc = 0;
      end else begin
        if (!e[6]) exp_sc++;
        if (e[3]) exp_fc++;
      end
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("stall_cycles%0d", i), stall_cycles, exp_sc);
      check($sformatf("flush_count%0d", i), flush_count, exp_fc);
`else
      check($sformatf("stall_cycles%0d", i), stall_cycles, 32'd0);
      check($sformatf("flush_count%0d", i), flush_count, 32'd0);
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
